tdm_demux: RTL and testbench

//   Receive end of the time-division mux link: one W-bit sample per clock on din, frame start marked by sync.

---
 rtl/tdm_demux.sv | 92 +++++++++
 tb/tb_tdm_demux.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// tdm_demux: receive side of the TDM link. It collects N_CH slot samples per
// frame into shadow registers and publishes the whole frame at once on
// ch_out. It hunts for sync, runs while framing holds, and flags framing
// errors.
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 1,
  parameter int SW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              sync,
  output logic [N_CH*W-1:0] ch_out,
  output logic              frame_valid,
  output logic [SW-1:0]     slot,
  output logic              locked,
  output logic              err
);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);

  state_t                  r_state;
  logic [SW-1:0]           r_slot;
  // Slots 0..N_CH-2 wait here. The last slot goes straight to ch_out, so
  // ch_out only ever changes once a whole frame has been collected.
  logic [(N_CH-1)*W-1:0]   r_shadow;
  logic [N_CH*W-1:0]       r_ch_out;
  logic                    r_frame_valid;
  logic                    r_err;

  // Framing FSM, slot counter, shadow capture and frame publish.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments. Every branch then
    // reads the pre-edge values of r_slot and r_shadow, whatever the
    // statement order.
    if (rst) begin
      // NOTE: the shadow registers are cleared on reset as well. A frame that
      // is only partly collected must not leak into the next published frame.
      r_state       <= HUNT;
      r_slot        <= '0;
      r_shadow      <= '0;
      r_ch_out      <= '0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
      unique case (r_state)
        HUNT: begin
          if (sync) begin
            r_shadow[0 +: W] <= din;
            r_slot           <= SW'(1);
            r_state          <= RUN;
          end
        end
        RUN: begin
          if (sync) begin
            // A sync mid-frame drops the partial frame. The sync cycle itself
            // becomes slot 0 of a new frame.
            if (r_slot != '0) r_err <= 1'b1;
            r_shadow[0 +: W] <= din;
            r_slot           <= SW'(1);
          end else if (r_slot == '0) begin
            // Expected sync did not arrive: lose lock and drop the sample.
            r_err   <= 1'b1;
            r_state <= HUNT;
          end else if (r_slot == LAST_SLOT) begin
            r_ch_out      <= {din, r_shadow};
            r_frame_valid <= 1'b1;
            r_slot        <= '0;
          end else begin
            for (int k = 1; k < N_CH - 1; k++) begin
              if (r_slot == SW'(k)) r_shadow[k*W +: W] <= din;
            end
            r_slot <= r_slot + SW'(1);
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  assign ch_out      = r_ch_out;
  assign frame_valid = r_frame_valid;
  assign slot        = r_slot;
  assign locked      = (r_state == RUN);
  assign err         = r_err;

endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux (N_CH=4, W=1). The reference model is a queue of
// the samples collected for the current frame, plus a hunting flag.
module tb_tdm_demux;
  localparam int N_CH = 4;
  localparam int W    = 1;
  localparam int SW   = 2;

  logic              clk;
  logic              rst;
  logic [W-1:0]      din;
  logic              sync;
  logic [N_CH*W-1:0] ch_out;
  logic              frame_valid;
  logic [SW-1:0]     slot;
  logic              locked;
  logic              err;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .sync(sync), .ch_out(ch_out),
    .frame_valid(frame_valid), .slot(slot), .locked(locked), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0]      m_q[$];
  bit                m_hunting = 1'b1;
  logic [N_CH*W-1:0] m_ch = '0;
  logic              m_fv = 1'b0;
  logic              m_errp = 1'b0;
  logic [SW-1:0]     m_slot = '0;
  logic              m_locked = 1'b0;

  // Advance the model by one clock using the framing rules.
  task automatic model_step(input logic r, input logic [W-1:0] d, input logic s);
    m_fv   = 1'b0;
    m_errp = 1'b0;
    if (r) begin
      m_q.delete();
      m_hunting = 1'b1;
      m_ch = '0;
    end else if (m_hunting) begin
      if (s) begin
        m_q.delete();
        m_q.push_back(d);
        m_hunting = 1'b0;
      end
    end else if (s) begin
      if (m_q.size() != 0) m_errp = 1'b1;
      m_q.delete();
      m_q.push_back(d);
    end else if (m_q.size() == 0) begin
      m_errp = 1'b1;
      m_hunting = 1'b1;
    end else begin
      m_q.push_back(d);
      if (m_q.size() == N_CH) begin
        for (int k = 0; k < N_CH; k++) m_ch[k*W +: W] = m_q[k];
        m_fv = 1'b1;
        m_q.delete();
      end
    end
    m_slot   = m_hunting ? '0 : SW'(m_q.size());
    m_locked = !m_hunting;
  endtask

  // Drive one cycle, step the model, then settle just after the edge.
  task automatic apply(input logic r, input logic [W-1:0] d, input logic s);
    rst  = r;
    din  = d;
    sync = s;
    @(posedge clk);
    model_step(r, d, s);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, W'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      n_vec++;
      if ({ch_out, frame_valid, slot, locked, err} !== {{N_CH*W{1'b0}}, 1'b0, {SW{1'b0}}, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reset: ch=%b fv=%b slot=%0d lk=%b err=%b, want all zero",
                 ch_out, frame_valid, slot, locked, err);
      end
    end
  endtask

  // Frame 1,0,1,1 after hunting: ch_out=1101 after the 4th edge.
  task automatic test_single_frame();
    logic [3:0] dv = 4'b1101;
    for (int i = 0; i < N_CH; i++) begin
      apply(1'b0, dv[i], i == 0);
      n_vec++;
      if ({ch_out, frame_valid, slot, locked, err} !== {m_ch, m_fv, m_slot, m_locked, m_errp}) begin
        n_err++;
        $display("FAIL single_frame cyc%0d: got %b/%b/%0d/%b/%b exp %b/%b/%0d/%b/%b", i,
                 ch_out, frame_valid, slot, locked, err, m_ch, m_fv, m_slot, m_locked, m_errp);
      end
    end
    n_vec++;
    if ({ch_out, frame_valid, locked} !== {4'b1101, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL single_frame result: ch=%b fv=%b lk=%b exp 1101/1/1", ch_out, frame_valid, locked);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] dv = 8'b0110_1101;
    int pulses = 0;
    int last_pulse = -1;
    for (int i = 0; i < 2 * N_CH; i++) begin
      apply(1'b0, dv[i], (i % N_CH) == 0);
      n_vec++;
      if ({ch_out, frame_valid, slot, locked, err} !== {m_ch, m_fv, m_slot, m_locked, m_errp}) begin
        n_err++;
        $display("FAIL back_to_back cyc%0d: got %b/%b/%0d/%b/%b exp %b/%b/%0d/%b/%b", i,
                 ch_out, frame_valid, slot, locked, err, m_ch, m_fv, m_slot, m_locked, m_errp);
      end
      if (frame_valid === 1'b1) begin
        if (pulses == 0) begin
          n_vec++;
          if (ch_out !== 4'b1101) begin
            n_err++;
            $display("FAIL back_to_back frame0: ch=%b exp 1101", ch_out);
          end
        end else begin
          n_vec++;
          if (ch_out !== 4'b0110 || (i - last_pulse) != N_CH) begin
            n_err++;
            $display("FAIL back_to_back frame1: ch=%b gap=%0d exp 0110 gap 4", ch_out, i - last_pulse);
          end
        end
        pulses++;
        last_pulse = i;
      end
    end
    n_vec++;
    if (pulses != 2) begin
      n_err++;
      $display("FAIL back_to_back pulses: got %0d exp 2", pulses);
    end
  endtask

  // Sync again at slot 2: err pulse, old frame held, new frame 1,1,1,1.
  task automatic test_early_sync();
    logic [5:0] dv = 6'b111100;
    logic [5:0] sv = 6'b000101;
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, dv[i], sv[i]);
      n_vec++;
      if ({ch_out, frame_valid, slot, locked, err} !== {m_ch, m_fv, m_slot, m_locked, m_errp}) begin
        n_err++;
        $display("FAIL early_sync cyc%0d: got %b/%b/%0d/%b/%b exp %b/%b/%0d/%b/%b", i,
                 ch_out, frame_valid, slot, locked, err, m_ch, m_fv, m_slot, m_locked, m_errp);
      end
      if (i == 2) begin
        n_vec++;
        if ({err, ch_out, locked} !== {1'b1, 4'b0110, 1'b1}) begin
          n_err++;
          $display("FAIL early_sync err: err=%b ch=%b lk=%b exp 1/0110/1", err, ch_out, locked);
        end
      end
    end
    n_vec++;
    if ({ch_out, frame_valid} !== {4'b1111, 1'b1}) begin
      n_err++;
      $display("FAIL early_sync result: ch=%b fv=%b exp 1111/1", ch_out, frame_valid);
    end
  endtask

  // Missing sync at slot 0: err, unlock, hold; relock with frame 0,0,1,0.
  task automatic test_missing_sync();
    logic [4:0] dv = 5'b01001;
    logic [4:0] sv = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, dv[i], sv[i]);
      n_vec++;
      if ({ch_out, frame_valid, slot, locked, err} !== {m_ch, m_fv, m_slot, m_locked, m_errp}) begin
        n_err++;
        $display("FAIL missing_sync cyc%0d: got %b/%b/%0d/%b/%b exp %b/%b/%0d/%b/%b", i,
                 ch_out, frame_valid, slot, locked, err, m_ch, m_fv, m_slot, m_locked, m_errp);
      end
      if (i == 0) begin
        n_vec++;
        if ({err, locked, ch_out} !== {1'b1, 1'b0, 4'b1111}) begin
          n_err++;
          $display("FAIL missing_sync err: err=%b lk=%b ch=%b exp 1/0/1111", err, locked, ch_out);
        end
      end
    end
    n_vec++;
    if ({ch_out, frame_valid, locked} !== {4'b0100, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL missing_sync result: ch=%b fv=%b lk=%b exp 0100/1/1", ch_out, frame_valid, locked);
    end
  endtask

  // Reset at slot 2 of a frame, then a clean frame 1,0,0,1.
  task automatic test_reset_midframe();
    logic [6:0] dv = 7'b1001_011;
    logic [6:0] sv = 7'b0001_001;
    logic [6:0] rv = 7'b0000_100;
    for (int i = 0; i < 7; i++) begin
      apply(rv[i], dv[i], sv[i]);
      n_vec++;
      if ({ch_out, frame_valid, slot, locked, err} !== {m_ch, m_fv, m_slot, m_locked, m_errp}) begin
        n_err++;
        $display("FAIL reset_midframe cyc%0d: got %b/%b/%0d/%b/%b exp %b/%b/%0d/%b/%b", i,
                 ch_out, frame_valid, slot, locked, err, m_ch, m_fv, m_slot, m_locked, m_errp);
      end
      if (i == 2) begin
        n_vec++;
        if ({ch_out, frame_valid, locked, slot} !== {4'b0000, 1'b0, 1'b0, 2'd0}) begin
          n_err++;
          $display("FAIL reset_midframe rst: ch=%b fv=%b lk=%b slot=%0d exp 0000/0/0/0",
                   ch_out, frame_valid, locked, slot);
        end
      end
    end
    n_vec++;
    if ({ch_out, frame_valid} !== {4'b1001, 1'b1}) begin
      n_err++;
      $display("FAIL reset_midframe result: ch=%b fv=%b exp 1001/1", ch_out, frame_valid);
    end
  endtask

  // Mostly well-framed random traffic with occasional sync glitches and resets.
  task automatic test_random();
    int phase = 0;
    for (int i = 0; i < 400; i++) begin
      logic r, s;
      r = ($urandom_range(99, 0) < 2);
      s = (phase == 0);
      if ($urandom_range(99, 0) < 8) s = ~s;
      phase = (phase + 1) % N_CH;
      apply(r, W'($urandom_range(1, 0)), s);
      n_vec++;
      if ({ch_out, frame_valid, slot, locked, err} !== {m_ch, m_fv, m_slot, m_locked, m_errp} ||
          (frame_valid && err) || slot > SW'(N_CH - 1)) begin
        n_err++;
        $display("FAIL random cyc%0d: got %b/%b/%0d/%b/%b exp %b/%b/%0d/%b/%b", i,
                 ch_out, frame_valid, slot, locked, err, m_ch, m_fv, m_slot, m_locked, m_errp);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    din  = '0;
    sync = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_early_sync();
    test_missing_sync();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
